// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - exception codes, FSM states and candidate record for exc_ctrl
//
// Shared by exc_prio_enc and exc_ctrl. The exception codes are the values
// driven on excepttype_o to CP0. EXC_INT is internal; CP0 maps it to ExcCode 0.
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_NONE = 5'h00;
    localparam logic [4:0] EXC_INT  = 5'h10;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;
    localparam logic [4:0] EXC_ERET = 5'h0E;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Everything CP0 needs about one exception, captured together so a
    // stalled candidate can be replayed unchanged at commit.
    typedef struct packed {
        logic [4:0]  code;
        logic        delayslot;
        logic [31:0] pc;
        logic [31:0] badvaddr;
    } cand_t;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fixed-priority encoder from MEM exception flags to (code, badvaddr)
//
// Ports:
//   valid                 MEM stage holds a real instruction
//   int_req               registered interrupt request
//   adel_if .. eret       per-instruction exception flags
//   pc, addr              instruction PC and data address
//   code                  selected exception code (EXC_NONE when nothing applies)
//   badvaddr              faulting address for address errors, else 0
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic        valid,
    input  logic        int_req,
    input  logic        adel_if,
    input  logic        ri,
    input  logic        ov,
    input  logic        syscall,
    input  logic        brk,
    input  logic        adel,
    input  logic        ades,
    input  logic        eret,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    output logic [4:0]  code,
    output logic [31:0] badvaddr
);

    always_comb begin
        code     = EXC_NONE;
        badvaddr = 32'h0;
        if (valid) begin
            if (int_req) begin
                code = EXC_INT;
            end else if (adel_if) begin
                code     = EXC_ADEL;
                badvaddr = pc;
            end else if (ri) begin
                code = EXC_RI;
            end else if (ov) begin
                code = EXC_OV;
            end else if (syscall) begin
                code = EXC_SYS;
            end else if (brk) begin
                code = EXC_BP;
            end else if (adel) begin
                code     = EXC_ADEL;
                badvaddr = addr;
            end else if (ades) begin
                code     = EXC_ADES;
                badvaddr = addr;
            end else if (eret) begin
                code = EXC_ERET;
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt controller between MEM stage and CP0
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall_i                       pipeline frozen; commit is deferred while high
//   mem_*                         MEM-stage instruction info and exception flags
//   status_i, cause_i, epc_i      CP0 state
//   excepttype_o .. badvaddr_o    one-cycle exception report to CP0
//   flush_o, new_pc_o             pipeline flush and redirect target
//   busy_o                        high while holding a stalled event or flushing
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic        mem_adel_if_i,
    input  logic        mem_ri_i,
    input  logic        mem_ov_i,
    input  logic        mem_syscall_i,
    input  logic        mem_break_i,
    input  logic        mem_adel_i,
    input  logic        mem_ades_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_eret_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic [4:0]  excepttype_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] current_inst_addr_o,
    output logic [31:0] badvaddr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t      state;
    logic [3:0]  flush_cnt;
    logic        int_req_q;
    cand_t       held;
    cand_t       live;
    cand_t       commit_cand;
    logic        commit_now;
    logic [4:0]  live_code;
    logic [31:0] live_badvaddr;

    // Only the interrupt-related fields of Status/Cause matter here.
    logic unused_ok;
    assign unused_ok = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    exc_prio_enc u_prio (
        .valid    (mem_valid_i),
        .int_req  (int_req_q),
        .adel_if  (mem_adel_if_i),
        .ri       (mem_ri_i),
        .ov       (mem_ov_i),
        .syscall  (mem_syscall_i),
        .brk      (mem_break_i),
        .adel     (mem_adel_i),
        .ades     (mem_ades_i),
        .eret     (mem_eret_i),
        .pc       (mem_pc_i),
        .addr     (mem_addr_i),
        .code     (live_code),
        .badvaddr (live_badvaddr)
    );

    always_comb begin
        live.code      = live_code;
        live.delayslot = mem_in_delayslot_i;
        live.pc        = mem_pc_i;
        live.badvaddr  = live_badvaddr;
    end

    // In HOLD the latched copy is committed, never the live MEM inputs,
    // because the MEM stage may already show a different instruction.
    always_comb begin
        commit_cand = (state == ST_HOLD) ? held : live;
        commit_now  = !stall_i &&
                      ((state == ST_HOLD) ||
                       (state == ST_IDLE && live.code != EXC_NONE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            flush_cnt           <= 4'd0;
            int_req_q           <= 1'b0;
            held                <= '0;
            excepttype_o        <= EXC_NONE;
            is_in_delayslot_o   <= 1'b0;
            current_inst_addr_o <= 32'h0;
            badvaddr_o          <= 32'h0;
            flush_o             <= 1'b0;
            new_pc_o            <= 32'h0;
            busy_o              <= 1'b0;
        end else begin
            int_req_q <= (|(cause_i[15:8] & status_i[15:8])) & status_i[0] & ~status_i[1];

            // The CP0 report is a single-cycle pulse.
            excepttype_o        <= EXC_NONE;
            is_in_delayslot_o   <= 1'b0;
            current_inst_addr_o <= 32'h0;
            badvaddr_o          <= 32'h0;

            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (commit_now) begin
                        excepttype_o        <= commit_cand.code;
                        is_in_delayslot_o   <= commit_cand.delayslot;
                        current_inst_addr_o <= commit_cand.pc;
                        badvaddr_o          <= commit_cand.badvaddr;
                        flush_o             <= 1'b1;
                        new_pc_o            <= (commit_cand.code == EXC_ERET) ? epc_i : EXC_VECTOR;
                        busy_o              <= 1'b1;
                        flush_cnt           <= FLUSH_INIT;
                        state               <= ST_FLUSH;
                    end else if (state == ST_IDLE && live.code != EXC_NONE) begin
                        held   <= live;
                        busy_o <= 1'b1;
                        state  <= ST_HOLD;
                    end
                end
                ST_FLUSH: begin
                    // Runs to completion regardless of stall_i.
                    if (flush_cnt <= 4'd1) begin
                        flush_cnt <= 4'd0;
                        flush_o   <= 1'b0;
                        busy_o    <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    flush_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
